// File: rtl/ray_wall_scheduler.sv
// Walks the wall list for one ray, feeding the combinational rayCast unit and keeping the nearest hit.
// Latency: 3 cycles per wall plus one result cycle (done in cycle 3N+1 after accept, cycle 1 for N=0).
// Backpressure: ready is high only when idle; start is ignored otherwise, with nothing queued.
module ray_wall_scheduler #(
  parameter int WALL_ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   ready,
  input  logic [63:0]            ray,
  input  logic [WALL_ADDR_W:0]   wall_count,
  output logic [WALL_ADDR_W-1:0] mem_addr,
  output logic                   mem_rd,
  input  logic [63:0]            mem_data,
  output logic [63:0]            rc_ray,
  output logic [63:0]            rc_wall,
  input  logic                   rc_intersection,
  input  logic [15:0]            rc_distance,
  input  logic [7:0]             rc_uv_x,
  output logic                   done,
  output logic                   hit,
  output logic [15:0]            hit_distance,
  output logic [7:0]             hit_uv_x,
  output logic [WALL_ADDR_W-1:0] hit_wall
);

  localparam logic [WALL_ADDR_W:0] MAX_WALLS = {1'b1, {WALL_ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EVAL,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [WALL_ADDR_W-1:0] idx;
  logic [WALL_ADDR_W-1:0] last_idx;
  logic [WALL_ADDR_W:0]   count_clamped;
  logic [WALL_ADDR_W:0]   count_m1;
  logic                   accept;
  logic                   closer;

  // The count is stored as the index of the last wall so the loop test is a plain equality.
  assign count_clamped = (wall_count > MAX_WALLS) ? MAX_WALLS : wall_count;
  assign count_m1      = count_clamped - (WALL_ADDR_W+1)'(1);
  assign accept        = start && (state == S_IDLE);
  assign closer        = rc_intersection && (!hit || (rc_distance < hit_distance));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    mem_rd    = 1'b0;
    done      = 1'b0;
    mem_addr  = idx;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_nxt = (wall_count == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        mem_rd    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_EVAL;
      end
      S_EVAL: begin
        state_nxt = (idx == last_idx) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx          <= '0;
      last_idx     <= '0;
      rc_ray       <= '0;
      rc_wall      <= '0;
      hit          <= 1'b0;
      hit_distance <= 16'hFFFF;
      hit_uv_x     <= '0;
      hit_wall     <= '0;
    end else begin
      if (accept) begin
        rc_ray       <= ray;
        last_idx     <= count_m1[WALL_ADDR_W-1:0];
        idx          <= '0;
        hit          <= 1'b0;
        hit_distance <= 16'hFFFF;
        hit_uv_x     <= '0;
        hit_wall     <= '0;
      end
      if (state == S_WAIT) begin
        rc_wall <= mem_data;
      end
      // Strict less-than keeps the lowest index on equal distances.
      if (state == S_EVAL) begin
        if (closer) begin
          hit          <= 1'b1;
          hit_distance <= rc_distance;
          hit_uv_x     <= rc_uv_x;
          hit_wall     <= idx;
        end
        if (idx != last_idx) begin
          idx <= idx + WALL_ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ray_wall_scheduler.sv
// Randomized and scripted bench for ray_wall_scheduler with a wall RAM model and a table-driven rayCast stub.
module tb_ray_wall_scheduler;

  localparam int W = 6;
  localparam int NW = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         ready;
  logic [63:0]  ray;
  logic [W:0]   wall_count;
  logic [W-1:0] mem_addr;
  logic         mem_rd;
  logic [63:0]  mem_data;
  logic [63:0]  rc_ray;
  logic [63:0]  rc_wall;
  logic         rc_intersection;
  logic [15:0]  rc_distance;
  logic [7:0]   rc_uv_x;
  logic         done;
  logic         hit;
  logic [15:0]  hit_distance;
  logic [7:0]   hit_uv_x;
  logic [W-1:0] hit_wall;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wall_mem [NW];
  logic        stub_hit [NW];
  logic [15:0] stub_dist [NW];
  logic [7:0]  stub_uv [NW];

  logic [W-1:0] addr_q[$];
  int           done_cnt;

  ray_wall_scheduler #(.WALL_ADDR_W(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .ready           (ready),
    .ray             (ray),
    .wall_count      (wall_count),
    .mem_addr        (mem_addr),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .rc_ray          (rc_ray),
    .rc_wall         (rc_wall),
    .rc_intersection (rc_intersection),
    .rc_distance     (rc_distance),
    .rc_uv_x         (rc_uv_x),
    .done            (done),
    .hit             (hit),
    .hit_distance    (hit_distance),
    .hit_uv_x        (hit_uv_x),
    .hit_wall        (hit_wall)
  );

  always #5 clk = ~clk;

  // Synchronous-read wall RAM.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= wall_mem[mem_addr];
  end

  // Each wall word carries its own index in x3, which the stub uses to pick the scripted result.
  assign rc_intersection = stub_hit[rc_wall[53:48]];
  assign rc_distance     = stub_dist[rc_wall[53:48]];
  assign rc_uv_x         = stub_uv[rc_wall[53:48]];

  always @(posedge clk) begin
    if (mem_rd) addr_q.push_back(mem_addr);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_tables();
    for (int i = 0; i < NW; i++) begin
      stub_hit[i]  = 1'b0;
      stub_dist[i] = 16'h0000;
      stub_uv[i]   = 8'h00;
    end
  endtask

  task automatic rand_tables();
    for (int i = 0; i < NW; i++) begin
      stub_hit[i]  = 1'($urandom_range(0, 1));
      stub_dist[i] = 16'($urandom_range(0, 3) << 8);
      if ($urandom_range(0, 7) == 0) stub_dist[i] = 16'hFFFF;
      stub_uv[i]   = 8'($urandom);
    end
  endtask

  // Nearest hit: smallest distance among hitting walls, then the first wall reaching it.
  task automatic model(input int n, output logic e_hit, output logic [15:0] e_d,
                       output logic [7:0] e_uv, output logic [W-1:0] e_w);
    int best;
    best = -1;
    for (int i = 0; i < n; i++)
      if (stub_hit[i] && (best < 0 || int'(stub_dist[i]) < best)) best = int'(stub_dist[i]);
    e_hit = 1'b0; e_d = 16'hFFFF; e_uv = 8'h00; e_w = '0;
    if (best >= 0) begin
      for (int i = n - 1; i >= 0; i--)
        if (stub_hit[i] && int'(stub_dist[i]) == best) begin
          e_hit = 1'b1; e_d = stub_dist[i]; e_uv = stub_uv[i]; e_w = W'(i);
        end
    end
  endtask

  // Called at a negedge; returns just after the accept edge.
  task automatic issue(input logic [63:0] r, input logic [W:0] wc);
    check("ready_before_start", ready, 1'b1);
    start      = 1'b1;
    ray        = r;
    wall_count = wc;
    addr_q.delete();
    done_cnt   = 0;
    @(posedge clk);
  endtask

  // Returns at the negedge of the cycle after done.
  task automatic finish_req(input int wc, input bit hold, input bit scramble, input logic [63:0] exp_ray);
    int n, c;
    bit seen;
    logic e_hit;
    logic [15:0] e_d;
    logic [7:0] e_uv;
    logic [W-1:0] e_w;
    n = (wc > NW) ? NW : wc;
    model(n, e_hit, e_d, e_uv, e_w);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 3 * NW + 20) begin
      @(negedge clk);
      c++;
      if (!hold) start = 1'b0;
      if (scramble) begin
        ray        = {$urandom, $urandom};
        wall_count = (W+1)'($urandom);
      end
      if (done) seen = 1'b1;
    end
    check("done_cycle", seen ? c : 9999, 3 * n + 1);
    check("hit", hit, e_hit);
    check("hit_distance", hit_distance, e_d);
    check("hit_uv_x", hit_uv_x, e_uv);
    check("hit_wall", hit_wall, e_w);
    check("rc_ray_latched", rc_ray, exp_ray);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("done_pulses", done_cnt, 1);
    check("ready_after_done", ready, 1'b1);
    check("result_hold", hit_distance, e_d);
    check("mem_rd_count", addr_q.size(), n);
    for (int i = 0; i < addr_q.size() && i < n; i++) check("mem_addr_seq", addr_q[i], i);
  endtask

  initial begin
    logic [63:0] r1;
    logic [63:0] r2;
    int wc;
    bit seen;

    for (int i = 0; i < NW; i++) wall_mem[i] = {16'(i), $urandom, 16'($urandom)};
    clear_tables();
    mem_data   = '0;
    reset      = 1'b1;
    start      = 1'b0;
    ray        = '0;
    wall_count = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rc_ray", rc_ray, 0);
    check("rst_rc_wall", rc_wall, 0);
    check("rst_hit", hit, 1'b0);
    check("rst_hit_distance", hit_distance, 16'hFFFF);
    check("rst_hit_uv_x", hit_uv_x, 0);
    check("rst_hit_wall", hit_wall, 0);

    // No walls.
    r1 = 64'h0001_0002_0003_0004;
    issue(r1, 0);
    finish_req(0, 0, 0, r1);

    // Miss, far hit, near hit.
    clear_tables();
    stub_hit[1] = 1'b1; stub_dist[1] = 16'h0200; stub_uv[1] = 8'h40;
    stub_hit[2] = 1'b1; stub_dist[2] = 16'h0100; stub_uv[2] = 8'h80;
    r1 = 64'h1111_2222_3333_4444;
    issue(r1, 3);
    finish_req(3, 0, 0, r1);

    // Equal distances: lowest index wins.
    clear_tables();
    stub_hit[0] = 1'b1; stub_dist[0] = 16'h0300; stub_uv[0] = 8'h11;
    stub_hit[1] = 1'b1; stub_dist[1] = 16'h0300; stub_uv[1] = 8'h22;
    r1 = 64'hAAAA_BBBB_CCCC_DDDD;
    issue(r1, 2);
    finish_req(2, 0, 0, r1);

    // A hit at the maximum distance still reports hit.
    clear_tables();
    stub_hit[1] = 1'b1; stub_dist[1] = 16'hFFFF; stub_uv[1] = 8'h5A;
    r1 = 64'h0F0F_F0F0_1234_5678;
    issue(r1, 3);
    finish_req(3, 0, 0, r1);

    // start held and inputs scrambled during the run; the next request rides the held start.
    rand_tables();
    r1 = {$urandom, $urandom};
    r2 = {$urandom, $urandom};
    issue(r1, 5);
    finish_req(5, 1, 1, r1);
    issue(r2, 4);
    finish_req(4, 0, 0, r2);

    // Counts at and beyond the memory size.
    rand_tables();
    r1 = {$urandom, $urandom};
    issue(r1, 100);
    finish_req(100, 0, 0, r1);
    r1 = {$urandom, $urandom};
    issue(r1, 64);
    finish_req(64, 0, 0, r1);

    // Reset during EVAL of wall 1 of 4, after wall 0 already hit.
    clear_tables();
    stub_hit[0] = 1'b1; stub_dist[0] = 16'h0050; stub_uv[0] = 8'h77;
    r1 = 64'h5555_6666_7777_8888;
    issue(r1, 4);
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_done", done, 1'b0);
    check("abort_mem_rd", mem_rd, 1'b0);
    check("abort_rc_ray", rc_ray, 0);
    check("abort_rc_wall", rc_wall, 0);
    check("abort_hit", hit, 1'b0);
    check("abort_hit_distance", hit_distance, 16'hFFFF);
    check("abort_hit_wall", hit_wall, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("abort_no_done", seen, 1'b0);
    r1 = {$urandom, $urandom};
    issue(r1, 4);
    finish_req(4, 0, 0, r1);

    // Random requests.
    repeat (6) begin
      rand_tables();
      wc = $urandom_range(0, 80);
      r1 = {$urandom, $urandom};
      issue(r1, (W+1)'(wc));
      finish_req(wc, 0, 0, r1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
